// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath selects,
// write strobes and the ALU operation code.
module multicycle_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] AluControl,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  state_t     state_q;
  state_t     state_d;
  state_t     dec_state;
  logic [1:0] alu_op;

  logic is_lw;
  logic is_sw;
  logic is_r;
  logic is_i;
  logic is_beq;
  logic is_jal;
  logic op_known;

  // Opcode classification shared by next-state, output and immediate decode
  always_comb begin
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
    is_r     = (op == OP_R);
    is_i     = (op == OP_I);
    is_beq   = (op == OP_BEQ);
    is_jal   = (op == OP_JAL);
    op_known = is_lw | is_sw | is_r | is_i | is_beq | is_jal;
  end

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= state_t'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; any unencoded state value falls back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_lw || is_sw)  state_d = S_MEMADR;
        else if (is_r)       state_d = S_EXECUTER;
        else if (is_i)       state_d = S_EXECUTEI;
        else if (is_beq)     state_d = S_BEQ;
        else if (is_jal)     state_d = S_JAL;
        else                 state_d = S_FETCH;
      end
      S_MEMADR: begin
        if (is_lw)           state_d = S_MEMREAD;
        else if (is_sw)      state_d = S_MEMWRITE;
        else                 state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // While in reset the selects show the FETCH decode regardless of the
  // current state; the strobes are squashed separately below.
  always_comb begin
    dec_state = rst ? S_FETCH : state_q;
  end

  // Moore output decode plus the mem_ready / zero gated strobes
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    RegWrite  = 1'b0;
    alu_op    = ALUOP_ADD;
    illegal   = 1'b0;
    case (dec_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        illegal = ~op_known;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        PCWrite = zero;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  // ALU operation decode from ALUOp and the instruction funct fields
  always_comb begin
    AluControl = 3'b000;
    case (alu_op)
      ALUOP_ADD: AluControl = 3'b000;
      ALUOP_SUB: AluControl = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  AluControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  AluControl = 3'b101;
          3'b110:  AluControl = 3'b011;
          3'b111:  AluControl = 3'b010;
          default: AluControl = 3'b000;
        endcase
      end
      default: AluControl = 3'b000;
    endcase
  end

  // Immediate format select, decoded from the opcode alone
  always_comb begin
    ImmSrc = 2'b00;
    if (is_sw)       ImmSrc = 2'b01;
    else if (is_beq) ImmSrc = 2'b10;
    else if (is_jal) ImmSrc = 2'b11;
    else             ImmSrc = 2'b00;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Control unit for the multicycle RISC-V datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. Each cycle it drives the datapath mux selects, the write strobes and the 3-bit AluControl code that the ALU consumes. It sits beside the datapath, taking instruction fields from the instruction register and the ALU zero flag.

Parameters:
RESET_STATE, 4'd0, encoding of FETCH loaded on reset. Not intended to be overridden.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
op  input  7  instruction opcode, instr[6:0]
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag (ALUResult == 0)
mem_ready  input  1  memory access completes this cycle
PCWrite  output  1  PC register write enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  data memory write strobe
IRWrite  output  1  instruction register (and OldPC) write enable
ResultSrc  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
ALUSrcB  output  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
RegWrite  output  1  register file write enable
ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
AluControl  output  3  ALU op code: 000 add, 001 sub, 010 and, 011 or, 101 slt
illegal  output  1  one-cycle pulse in DECODE for an unsupported opcode

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state <= FETCH on the clk edge with rst=1. While rst=1, PCWrite, IRWrite, MemWrite, RegWrite and illegal are forced to 0 combinationally. Other outputs show the FETCH decode.
- Outputs are Moore (state-decoded), except:
  - PCWrite and IRWrite in FETCH are gated by mem_ready.
  - Branch PCWrite in BEQ is gated by zero.
  - ImmSrc and the funct-based AluControl decode from op/funct3/funct7b5.
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- States, with asserted outputs (unlisted strobes = 0, selects = 00) and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. Go to DECODE if mem_ready, else stay.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute). Next state by op: lw/sw->MEMADR, R->EXECUTER, I-ALU->EXECUTEI, beq->BEQ, jal->JAL, other->FETCH with illegal=1.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Go to MEMWB if mem_ready, else stay.
  - MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 (held until mem_ready). Go to FETCH if mem_ready.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero. Go to FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Go to ALUWB.
- AluControl from the internal ALUOp:
  - ALUOp 00 -> 000.
  - ALUOp 01 -> 001.
  - ALUOp 10 decodes funct3:
    - 000: 001 if op[5]&funct7b5, else 000.
    - 010: 101.
    - 110: 011.
    - 111: 010.
    - any other: 000.
- ImmSrc: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.
- Latency with mem_ready=1 (cycles per instruction): lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2. Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Boundaries:
  - rst=1 in any state returns to FETCH on the next edge; no strobe fires in that cycle.
  - rst and mem_ready both high: reset wins.
  - Unencoded state values recover to FETCH.

Test Plan:
- Reset: rst=1 for 2 cycles from arbitrary state -> state FETCH; PCWrite=IRWrite=MemWrite=RegWrite=0 during rst; AluControl=000 after release.
- R-type sub (op=0110011, funct3=000, funct7b5=1), mem_ready=1 -> FETCH, DECODE, EXECUTER (AluControl=001), ALUWB (RegWrite=1), FETCH: 4 cycles.
- lw with mem_ready low 2 cycles in MEMREAD -> MEMREAD held 3 cycles, AdrSrc=1; then MEMWB with ResultSrc=01, RegWrite=1; 7 cycles total.
- beq with zero=1 vs zero=0 -> BEQ asserts AluControl=001; PCWrite=1 in the first case, 0 in the second; both return to FETCH after 3 cycles.
- I-ALU funct3 010/110/111 and funct7b5=1 with funct3=000 -> AluControl 101/011/010/000 in EXECUTEI; ImmSrc=00.
- op=1111111 -> illegal=1 for exactly one cycle in DECODE, then FETCH; no RegWrite or MemWrite pulse.
